serial_tofed_checker: RTL and testbench
=======================================

Name: serial_tofed_checker

Overview:
- Parametrised serial TOFED checker, successor to the fixed 5-bit / 3-ones definition.
- Frames a serial bitstream into fbibbles of FBIBBLE_SIZE bits after a sync marker.
- Checks each fbibble's ones count against ONESPERFBIBBLE, either exactly or at-least depending on MODE.
- Reports per-fbibble verdicts, detects framing aborts, and keeps saturating good/error counters. Sits between the serial line receiver and the link-status logic.

Parameters:
- FBIBBLE_SIZE, 5, bits per fbibble (legal range 2..32).
- ONESPERFBIBBLE, 3, required ones count (legal range 0..FBIBBLE_SIZE).
- MODE, 0, check mode: 0 = ones count must equal ONESPERFBIBBLE; 1 = ones count must be >= ONESPERFBIBBLE.
- CNT_WIDTH, 8, width of the good and error counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled only on cycles where this is 1.
- sync  in  1  qualified by din_valid; marks the current din as bit 0 of a new fbibble.
- clr_cnt  in  1  synchronous clear of good_count and err_count.
- fbibble_done  out  1  one-cycle pulse when a complete fbibble has been checked.
- fbibble_ok  out  1  valid with fbibble_done: the fbibble passed.
- fbibble_err  out  1  valid with fbibble_done: the fbibble failed.
- frame_err  out  1  one-cycle pulse when a partial fbibble is aborted by sync.
- last_fbibble  out  FBIBBLE_SIZE  last completed fbibble; bit 0 holds the first received bit.
- good_count  out  CNT_WIDTH  number of passing fbibbles, saturating.
- err_count  out  CNT_WIDTH  fbibble errors plus framing errors, saturating.
- locked  out  1  1 while in state COLLECT.

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE and zeroes every output, the bit counter, the ones counter and the shift register.
- State IDLE:
  - Bits without sync are ignored.
  - din_valid & sync: accept din as bit 0, bit_cnt=1, ones_cnt=din, go to COLLECT.
- State COLLECT:
  - Each din_valid cycle without sync shifts din into position bit_cnt, increments bit_cnt, and adds din to ones_cnt.
  - Cycles with din_valid=0 hold all state (gaps allowed anywhere).
- Completion:
  - The fbibble completes when the bit accepted has bit_cnt==FBIBBLE_SIZE-1.
  - The next cycle (1-cycle latency, registered) raises fbibble_done=1 and updates last_fbibble.
  - Exactly one of fbibble_ok / fbibble_err is 1. The verdict uses the final ones total including the last bit.
  - On the completing cycle, bit_cnt and ones_cnt return to 0 and the state stays COLLECT, so back-to-back fbibbles need no new sync.
- Sync in COLLECT with bit_cnt>0:
  - Abort the partial fbibble: frame_err pulses the next cycle and err_count increments.
  - The sync bit becomes bit 0 of a new fbibble; no fbibble_done is raised for the aborted one.
- Sync in COLLECT with bit_cnt==0: treated as a normal bit 0, with no frame_err.
- Sync on the cycle that would complete a fbibble: the abort wins. frame_err is raised, no fbibble_done is raised, and the sync bit starts a new fbibble.
- Outputs when no event occurs: fbibble_ok, fbibble_err and fbibble_done are 0 outside the done pulse; frame_err is 0 outside its pulse.
- Counters:
  - Saturate at 2^CNT_WIDTH-1 and never wrap.
  - err_count adds 1 per fbibble_err or frame_err; the two cannot coincide.
  - clr_cnt zeroes both counters. If clr_cnt coincides with an increment, the clear wins and the result is 0.
- Widths:
  - bit_cnt is $clog2(FBIBBLE_SIZE) bits.
  - ones_cnt is $clog2(FBIBBLE_SIZE+1) bits and cannot overflow.
  - The comparison is unsigned.
- locked drops only on reset; there is no loss-of-lock detection in this block.

Test Plan:
- Defaults. Send sync+1, then 0,1,0,1 (pattern 10101) -> one cycle after the 5th bit: fbibble_done=1, fbibble_ok=1, last_fbibble=5'b10101, good_count=1, err_count=0.
- Defaults. After sync, send 11111 then 00111 back-to-back -> first done with fbibble_err=1 and err_count=1; second done with fbibble_ok=1 and good_count=1. There is no sync between them.
- MODE=1. Send 11110 -> fbibble_ok=1. Send 11000 -> fbibble_err=1.
- Defaults. After sync send 1,1,0, then sync+1 -> frame_err pulses, err_count=1, no fbibble_done. The following 0,1,0,1 completes a fbibble with ok=1.
- din_valid low for 3 cycles between every bit of 10101 -> same result as the first scenario. fbibble_done comes 1 cycle after the 5th valid bit.
- CNT_WIDTH=2. Send six failing fbibbles -> err_count stops at 3. Then clr_cnt on the cycle of a 7th error -> err_count=0. An async reset mid-fbibble returns locked=0 and all outputs to 0 immediately.

Source files
------------

// File: rtl/serial_tofed_checker.sv
// serial_tofed_checker: frames a serial bitstream into FBIBBLE_SIZE-bit fbibbles after a
//   sync marker and checks each one's ones count (exact or at-least, by MODE).
// Latency: verdict, last_fbibble and counters update 1 cycle after the completing bit.
// Backpressure: none; din_valid gaps hold all state, and every valid bit is consumed.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   din, din_valid, sync  - serial bit, its qualifier, start-of-fbibble marker
//   clr_cnt               - synchronous clear of good_count / err_count
//   fbibble_done/ok/err   - one-cycle verdict pulse for a completed fbibble
//   frame_err             - one-cycle pulse when a partial fbibble is aborted by sync
//   last_fbibble          - last completed fbibble, bit 0 = first received bit
//   good_count, err_count - saturating event counters
//   locked                - high once a sync has been seen (until reset)
module serial_tofed_checker #(
  parameter int FBIBBLE_SIZE   = 5,
  parameter int ONESPERFBIBBLE = 3,
  parameter int MODE           = 0,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    sync,
  input  logic                    clr_cnt,
  output logic                    fbibble_done,
  output logic                    fbibble_ok,
  output logic                    fbibble_err,
  output logic                    frame_err,
  output logic [FBIBBLE_SIZE-1:0] last_fbibble,
  output logic [CNT_WIDTH-1:0]    good_count,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic                    locked
);

  localparam int BW = $clog2(FBIBBLE_SIZE);
  localparam int OW = $clog2(FBIBBLE_SIZE + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(FBIBBLE_SIZE - 1);
  localparam logic [OW-1:0] ONES_REQ = OW'(ONESPERFBIBBLE);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t                  state;
  logic [BW-1:0]           bit_cnt;
  logic [OW-1:0]           ones_cnt;
  logic [FBIBBLE_SIZE-1:0] shreg;

  logic [OW-1:0]           ones_total;
  logic [FBIBBLE_SIZE-1:0] fbibble_full;
  logic                    pass;
  logic                    start;
  logic                    abort;
  logic                    complete;
  logic                    inc_good;
  logic                    inc_err;

  always_comb begin
    // Totals include the bit being accepted this cycle, so the verdict on the
    // completing cycle already sees the final ones count.
    ones_total            = ones_cnt + OW'(din);
    fbibble_full          = shreg;
    fbibble_full[bit_cnt] = din;
    if (MODE == 0) pass = (ones_total == ONES_REQ);
    else           pass = (ones_total >= ONES_REQ);

    start    = din_valid & sync;
    // A sync landing on what would be the last bit is still an abort: it wins
    // over completion because bit_cnt is non-zero there.
    abort    = start & (state == COLLECT) & (bit_cnt != '0);
    complete = din_valid & ~sync & (state == COLLECT) & (bit_cnt == LAST_IDX);
    inc_good = complete & pass;
    inc_err  = (complete & ~pass) | abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      ones_cnt     <= '0;
      shreg        <= '0;
      fbibble_done <= 1'b0;
      fbibble_ok   <= 1'b0;
      fbibble_err  <= 1'b0;
      frame_err    <= 1'b0;
      last_fbibble <= '0;
      good_count   <= '0;
      err_count    <= '0;
      locked       <= 1'b0;
    end else begin
      fbibble_done <= complete;
      fbibble_ok   <= complete & pass;
      fbibble_err  <= complete & ~pass;
      frame_err    <= abort;
      if (complete) last_fbibble <= fbibble_full;

      if (start) begin
        // Sync always opens a fresh fbibble with the current bit as bit 0.
        state    <= COLLECT;
        locked   <= 1'b1;
        shreg    <= FBIBBLE_SIZE'(din);
        bit_cnt  <= BW'(1);
        ones_cnt <= OW'(din);
      end else if (din_valid && state == COLLECT) begin
        if (complete) begin
          // Stay in COLLECT: the next valid bit is bit 0 of the next fbibble.
          shreg    <= '0;
          bit_cnt  <= '0;
          ones_cnt <= '0;
        end else begin
          shreg    <= fbibble_full;
          bit_cnt  <= bit_cnt + BW'(1);
          ones_cnt <= ones_total;
        end
      end

      if (clr_cnt) begin
        good_count <= '0;
        err_count  <= '0;
      end else begin
        if (inc_good && good_count != '1) good_count <= good_count + 1'b1;
        if (inc_err  && err_count  != '1) err_count  <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_tofed_checker.sv
module tb_serial_tofed_checker;

  logic clk = 1'b0;
  logic reset, din, din_valid, sync, clr_cnt;
  always #5 clk = ~clk;

  // u0: defaults, u1: MODE=1 (at-least), u2: CNT_WIDTH=2. All share one input stream.
  logic       d0_done, d0_ok, d0_err, d0_ferr, d0_locked;
  logic [4:0] d0_last;
  logic [7:0] d0_good, d0_errc;
  logic       d1_done, d1_ok, d1_err, d1_ferr, d1_locked;
  logic [4:0] d1_last;
  logic [7:0] d1_good, d1_errc;
  logic       d2_done, d2_ok, d2_err, d2_ferr, d2_locked;
  logic [4:0] d2_last;
  logic [1:0] d2_good, d2_errc;

  serial_tofed_checker u0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync), .clr_cnt(clr_cnt),
    .fbibble_done(d0_done), .fbibble_ok(d0_ok), .fbibble_err(d0_err), .frame_err(d0_ferr),
    .last_fbibble(d0_last), .good_count(d0_good), .err_count(d0_errc), .locked(d0_locked));

  serial_tofed_checker #(.MODE(1)) u1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync), .clr_cnt(clr_cnt),
    .fbibble_done(d1_done), .fbibble_ok(d1_ok), .fbibble_err(d1_err), .frame_err(d1_ferr),
    .last_fbibble(d1_last), .good_count(d1_good), .err_count(d1_errc), .locked(d1_locked));

  serial_tofed_checker #(.CNT_WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync), .clr_cnt(clr_cnt),
    .fbibble_done(d2_done), .fbibble_ok(d2_ok), .fbibble_err(d2_err), .frame_err(d2_ferr),
    .last_fbibble(d2_last), .good_count(d2_good), .err_count(d2_errc), .locked(d2_locked));

  int tests = 0;
  int fails = 0;

  // Expected events: frame abort, or completed fbibble with verdicts for exact (ok0)
  // and at-least (ok1) modes plus its contents.
  typedef struct packed {
    logic       frame;
    logic       ok0;
    logic       ok1;
    logic [4:0] data;
  } ev_t;

  ev_t q0[$], q1[$], q2[$];
  ev_t e0, e1, e2;

  // Reference model of the framer, driven alongside the stimulus.
  logic       m_locked;
  int         m_cnt, m_ones;
  logic [4:0] m_data;

  task automatic model_clear();
    m_locked = 1'b0; m_cnt = 0; m_ones = 0; m_data = '0;
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic push_ev(input ev_t ev);
    q0.push_back(ev); q1.push_back(ev); q2.push_back(ev);
  endtask

  // One valid bit; returns 1 time unit after the sampling edge.
  task automatic send(input logic d, input logic s, input logic c);
    ev_t ev;
    if (s) begin
      if (m_locked && m_cnt > 0) begin
        ev = '0; ev.frame = 1'b1; push_ev(ev);
      end
      m_locked = 1'b1; m_data = '0; m_data[0] = d; m_cnt = 1; m_ones = int'(d);
    end else if (m_locked) begin
      m_data[m_cnt] = d;
      m_ones += int'(d);
      if (m_cnt == 4) begin
        ev.frame = 1'b0; ev.ok0 = (m_ones == 3); ev.ok1 = (m_ones >= 3); ev.data = m_data;
        push_ev(ev);
        m_cnt = 0; m_ones = 0; m_data = '0;
      end else begin
        m_cnt++;
      end
    end
    din = d; sync = s; clr_cnt = c; din_valid = 1'b1;
    @(posedge clk); #1;
    din = 1'b0; sync = 1'b0; clr_cnt = 1'b0; din_valid = 1'b0;
  endtask

  // w[0] is sent first.
  task automatic send_word(input logic [4:0] w, input logic first_sync);
    for (int i = 0; i < 5; i++) send(w[i], first_sync && (i == 0), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0; clr_cnt = 1'b0;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
  endtask

  // Scoreboard monitors: every DUT event must match the head of its queue.
  always @(negedge clk) if (!reset && (d0_done || d0_ferr)) begin
    tests++;
    if (q0.size() == 0) begin
      fails++; $display("FAIL u0_unexpected_event done=%b ferr=%b", d0_done, d0_ferr);
    end else begin
      e0 = q0.pop_front();
      if (e0.frame) begin
        if (d0_ferr !== 1'b1 || d0_done !== 1'b0) begin
          fails++; $display("FAIL u0_frame_event got ferr=%b done=%b want ferr=1 done=0", d0_ferr, d0_done);
        end
      end else if (d0_done !== 1'b1 || d0_ferr !== 1'b0 || d0_ok !== e0.ok0 || d0_err !== !e0.ok0 || d0_last !== e0.data) begin
        fails++;
        $display("FAIL u0_done_event got done=%b ok=%b err=%b last=%b want ok=%b err=%b last=%b",
                 d0_done, d0_ok, d0_err, d0_last, e0.ok0, !e0.ok0, e0.data);
      end
    end
  end

  always @(negedge clk) if (!reset && (d1_done || d1_ferr)) begin
    tests++;
    if (q1.size() == 0) begin
      fails++; $display("FAIL u1_unexpected_event done=%b ferr=%b", d1_done, d1_ferr);
    end else begin
      e1 = q1.pop_front();
      if (e1.frame) begin
        if (d1_ferr !== 1'b1 || d1_done !== 1'b0) begin
          fails++; $display("FAIL u1_frame_event got ferr=%b done=%b want ferr=1 done=0", d1_ferr, d1_done);
        end
      end else if (d1_done !== 1'b1 || d1_ferr !== 1'b0 || d1_ok !== e1.ok1 || d1_err !== !e1.ok1 || d1_last !== e1.data) begin
        fails++;
        $display("FAIL u1_done_event got done=%b ok=%b err=%b last=%b want ok=%b err=%b last=%b",
                 d1_done, d1_ok, d1_err, d1_last, e1.ok1, !e1.ok1, e1.data);
      end
    end
  end

  always @(negedge clk) if (!reset && (d2_done || d2_ferr)) begin
    tests++;
    if (q2.size() == 0) begin
      fails++; $display("FAIL u2_unexpected_event done=%b ferr=%b", d2_done, d2_ferr);
    end else begin
      e2 = q2.pop_front();
      if (e2.frame) begin
        if (d2_ferr !== 1'b1 || d2_done !== 1'b0) begin
          fails++; $display("FAIL u2_frame_event got ferr=%b done=%b want ferr=1 done=0", d2_ferr, d2_done);
        end
      end else if (d2_done !== 1'b1 || d2_ferr !== 1'b0 || d2_ok !== e2.ok0 || d2_err !== !e2.ok0 || d2_last !== e2.data) begin
        fails++;
        $display("FAIL u2_done_event got done=%b ok=%b err=%b last=%b want ok=%b err=%b last=%b",
                 d2_done, d2_ok, d2_err, d2_last, e2.ok0, !e2.ok0, e2.data);
      end
    end
  end

  // Missing events show up as entries left in a queue after a short drain window.
  task automatic test_drain(input string name);
    idle(3);
    tests++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_events left u0=%0d u1=%0d u2=%0d want 0", name, q0.size(), q1.size(), q2.size());
    end
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({d0_done, d0_ok, d0_err, d0_ferr, d0_locked} !== 5'b0 || d0_last !== 5'd0 ||
        d0_good !== 8'd0 || d0_errc !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs done=%b ok=%b err=%b ferr=%b locked=%b last=%b good=%0d errc=%0d want all 0",
               d0_done, d0_ok, d0_err, d0_ferr, d0_locked, d0_last, d0_good, d0_errc);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_word(5'b10101, 1'b1);
    tests++;
    if (d0_done !== 1'b1 || d0_ok !== 1'b1 || d0_last !== 5'b10101 || d0_good !== 8'd1 ||
        d0_errc !== 8'd0 || d0_locked !== 1'b1) begin
      fails++;
      $display("FAIL basic_10101 done=%b ok=%b last=%b good=%0d errc=%0d locked=%b want 1 1 10101 1 0 1",
               d0_done, d0_ok, d0_last, d0_good, d0_errc, d0_locked);
    end
    test_drain("basic");
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_word(5'b11111, 1'b1);
    tests++;
    if (d0_err !== 1'b1 || d0_errc !== 8'd1) begin
      fails++; $display("FAIL b2b_first err=%b errc=%0d want 1 1", d0_err, d0_errc);
    end
    send_word(5'b11100, 1'b0);  // sent as 0,0,1,1,1 with no sync
    tests++;
    if (d0_ok !== 1'b1 || d0_good !== 8'd1 || d0_errc !== 8'd1 || d0_last !== 5'b11100) begin
      fails++; $display("FAIL b2b_second ok=%b good=%0d errc=%0d last=%b want 1 1 1 11100", d0_ok, d0_good, d0_errc, d0_last);
    end
    // A sync at bit_cnt==0 is a plain bit 0, not an abort.
    send(1'b1, 1'b1, 1'b0);
    tests++;
    if (d0_ferr !== 1'b0 || d0_errc !== 8'd1) begin
      fails++; $display("FAIL sync_at_zero ferr=%b errc=%0d want 0 1", d0_ferr, d0_errc);
    end
    for (int i = 0; i < 4; i++) send(i[0], 1'b0, 1'b0);  // 0,1,0,1
    tests++;
    if (d0_ok !== 1'b1 || d0_good !== 8'd2) begin
      fails++; $display("FAIL sync_at_zero_done ok=%b good=%0d want 1 2", d0_ok, d0_good);
    end
    test_drain("b2b");
  endtask

  task automatic test_mode1();
    do_reset();
    send_word(5'b01111, 1'b1);  // sent 1,1,1,1,0
    tests++;
    if (d1_ok !== 1'b1 || d1_err !== 1'b0 || d0_err !== 1'b1) begin
      fails++; $display("FAIL mode1_11110 u1_ok=%b u1_err=%b u0_err=%b want 1 0 1", d1_ok, d1_err, d0_err);
    end
    send_word(5'b00011, 1'b0);  // sent 1,1,0,0,0
    tests++;
    if (d1_err !== 1'b1 || d1_ok !== 1'b0 || d1_good !== 8'd1 || d1_errc !== 8'd1) begin
      fails++; $display("FAIL mode1_11000 err=%b ok=%b good=%0d errc=%0d want 1 0 1 1", d1_err, d1_ok, d1_good, d1_errc);
    end
    test_drain("mode1");
  endtask

  task automatic test_frame_abort();
    do_reset();
    send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    tests++;
    if (d0_ferr !== 1'b1 || d0_done !== 1'b0 || d0_errc !== 8'd1) begin
      fails++; $display("FAIL abort ferr=%b done=%b errc=%0d want 1 0 1", d0_ferr, d0_done, d0_errc);
    end
    for (int i = 0; i < 4; i++) send(i[0], 1'b0, 1'b0);
    tests++;
    if (d0_ok !== 1'b1 || d0_last !== 5'b10101 || d0_good !== 8'd1) begin
      fails++; $display("FAIL abort_then_ok ok=%b last=%b good=%0d want 1 10101 1", d0_ok, d0_last, d0_good);
    end
    test_drain("abort");
  endtask

  task automatic test_sync_on_complete();
    do_reset();
    send(1'b1, 1'b1, 1'b0); send(1'b1, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);  // would have been bit 4
    tests++;
    if (d0_ferr !== 1'b1 || d0_done !== 1'b0 || d0_errc !== 8'd1 || d0_good !== 8'd0) begin
      fails++; $display("FAIL sync_on_complete ferr=%b done=%b errc=%0d good=%0d want 1 0 1 0", d0_ferr, d0_done, d0_errc, d0_good);
    end
    for (int i = 0; i < 4; i++) send(i[0], 1'b0, 1'b0);
    tests++;
    if (d0_ok !== 1'b1 || d0_last !== 5'b10101) begin
      fails++; $display("FAIL sync_on_complete_next ok=%b last=%b want 1 10101", d0_ok, d0_last);
    end
    test_drain("sync_complete");
  endtask

  task automatic test_gaps();
    logic [4:0] w;
    do_reset();
    w = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      send(w[i], i == 0, 1'b0);
      if (i < 4) idle(3);
    end
    tests++;
    if (d0_done !== 1'b1 || d0_ok !== 1'b1 || d0_last !== 5'b10101 || d0_good !== 8'd1) begin
      fails++; $display("FAIL gaps done=%b ok=%b last=%b good=%0d want 1 1 10101 1", d0_done, d0_ok, d0_last, d0_good);
    end
    test_drain("gaps");
  endtask

  task automatic test_saturation();
    do_reset();
    send_word(5'b11111, 1'b1);
    for (int i = 0; i < 5; i++) send_word(5'b11111, 1'b0);
    tests++;
    if (d2_errc !== 2'd3 || d0_errc !== 8'd6) begin
      fails++; $display("FAIL saturate u2_errc=%0d u0_errc=%0d want 3 6", d2_errc, d0_errc);
    end
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b1);  // 7th error completes with clr_cnt
    tests++;
    if (d2_err !== 1'b1 || d2_errc !== 2'd0 || d0_errc !== 8'd0) begin
      fails++; $display("FAIL clr_wins err=%b u2_errc=%0d u0_errc=%0d want 1 0 0", d2_err, d2_errc, d0_errc);
    end
    test_drain("saturation");
  endtask

  task automatic test_async_reset();
    do_reset();
    send_word(5'b10101, 1'b1);
    send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    model_clear();
    #1;
    tests++;
    if ({d0_done, d0_ok, d0_err, d0_ferr, d0_locked} !== 5'b0 || d0_last !== 5'd0 ||
        d0_good !== 8'd0 || d0_errc !== 8'd0 || d2_locked !== 1'b0) begin
      fails++;
      $display("FAIL async_reset locked=%b done=%b ok=%b last=%b good=%0d errc=%0d want all 0",
               d0_locked, d0_done, d0_ok, d0_last, d0_good, d0_errc);
    end
    idle(1);
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0; clr_cnt = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_back_to_back();
    test_mode1();
    test_frame_abort();
    test_sync_on_complete();
    test_gaps();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
